// File: rtl/craps_pkg.sv
// -----------------------------------------------------------------------------
// craps_pkg
// Shared definitions for the craps round controller:
//   - state_t      : 3-bit round state encoding (IDLE/COMEOUT/POINT/WIN/LOSE)
//   - SUM_*/CRAPS_*: dice-sum constants used by the classifier and the FSM
//   - state_busy() : true for the two states in which a roll is requested
// No ports (package).
// -----------------------------------------------------------------------------
package craps_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COMEOUT = 3'd1,
      ST_POINT   = 3'd2,
      ST_WIN     = 3'd3,
      ST_LOSE    = 3'd4
   } state_t;

   localparam int SUM_MIN    = 2;
   localparam int SUM_MAX    = 12;
   localparam int SUM_SEVEN  = 7;
   localparam int SUM_ELEVEN = 11;
   localparam int CRAPS_2    = 2;
   localparam int CRAPS_3    = 3;
   localparam int CRAPS_12   = 12;

   // A round is "in progress" (and rolls are requested) only while the
   // come-out roll or the point phase is pending.
   function automatic logic state_busy(input state_t s);
      return (s == ST_COMEOUT) || (s == ST_POINT);
   endfunction

endpackage

// File: rtl/craps_sum_classify.sv
// -----------------------------------------------------------------------------
// craps_sum_classify
// Purely combinational classification of a raw two-dice sum.
// Ports:
//   roll_sum [SUM_W-1:0] in  : raw dice sum (full width is examined)
//   legal                out : sum in 2..12
//   natural              out : sum is 7 or 11
//   craps                out : sum is 2, 3 or 12
//   seven                out : sum is 7
// -----------------------------------------------------------------------------
module craps_sum_classify #(
   parameter int SUM_W = 4
) (
   input  logic [SUM_W-1:0] roll_sum,
   output logic             legal,
   output logic             natural,
   output logic             craps,
   output logic             seven
);
   import craps_pkg::*;

   // Constants widened to the full sum width so that large out-of-range
   // values (e.g. 18 on a 5-bit bus) can never alias onto a legal sum.
   localparam logic [SUM_W-1:0] K_MIN    = SUM_W'(SUM_MIN);
   localparam logic [SUM_W-1:0] K_MAX    = SUM_W'(SUM_MAX);
   localparam logic [SUM_W-1:0] K_SEVEN  = SUM_W'(SUM_SEVEN);
   localparam logic [SUM_W-1:0] K_ELEVEN = SUM_W'(SUM_ELEVEN);
   localparam logic [SUM_W-1:0] K_C2     = SUM_W'(CRAPS_2);
   localparam logic [SUM_W-1:0] K_C3     = SUM_W'(CRAPS_3);
   localparam logic [SUM_W-1:0] K_C12    = SUM_W'(CRAPS_12);

   always_comb begin
      legal   = (roll_sum >= K_MIN) && (roll_sum <= K_MAX);
      seven   = (roll_sum == K_SEVEN);
      natural = seven || (roll_sum == K_ELEVEN);
      craps   = (roll_sum == K_C2) || (roll_sum == K_C3) || (roll_sum == K_C12);
   end

endmodule

// File: rtl/craps_round_ctrl.sv
// -----------------------------------------------------------------------------
// craps_round_ctrl
// Complete craps round controller: come-out roll, point phase, win/lose.
// Rolls are requested from the dice datapath with roll_req/roll_valid and the
// raw sum is classified internally. All outputs are registered; every effect
// of an accepted roll appears on the cycle after acceptance.
//
// Optional build macro: CRAPS_STATS_EN -- when defined, saturating win/loss
// tallies are built (cleared only by reset); otherwise wins/losses read 0.
//
// Ports:
//   clk_main              in  : system clock (rising edge)
//   reset                 in  : synchronous active-high reset
//   enter                 in  : start pulse, honoured only outside a round
//   roll_valid            in  : roll_sum valid this cycle
//   roll_sum  [SUM_W-1:0] in  : raw dice sum
//   roll_req              out : roll requested (COMEOUT or POINT)
//   sp                    out : 1-cycle point load strobe
//   point_val [SUM_W-1:0] out : latched point, 0 when none
//   win / lose            out : round result, held until next round
//   busy                  out : round in progress
//   sum_err               out : 1-cycle pulse for an illegal requested sum
//   roll_count[CNT_W-1:0] out : accepted rolls this round (saturating)
//   wins/losses[CNT_W-1:0]out : lifetime tallies (CRAPS_STATS_EN)
// -----------------------------------------------------------------------------
module craps_round_ctrl #(
   parameter int SUM_W           = 4,
   parameter int CNT_W           = 8,
   parameter int MAX_POINT_ROLLS = 0
) (
   input  logic             clk_main,
   input  logic             reset,
   input  logic             enter,
   input  logic             roll_valid,
   input  logic [SUM_W-1:0] roll_sum,
   output logic             roll_req,
   output logic             sp,
   output logic [SUM_W-1:0] point_val,
   output logic             win,
   output logic             lose,
   output logic             busy,
   output logic             sum_err,
   output logic [CNT_W-1:0] roll_count,
   output logic [CNT_W-1:0] wins,
   output logic [CNT_W-1:0] losses
);
   import craps_pkg::*;

   // Point-phase roll counter only needs to reach MAX_POINT_ROLLS-1: it holds
   // the number of point rolls already taken before the current one.
   localparam int PR_W = (MAX_POINT_ROLLS > 1) ? $clog2(MAX_POINT_ROLLS) : 1;

   state_t           state_q, state_d;
   logic [SUM_W-1:0] point_q, point_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PR_W-1:0]  pr_cnt_q, pr_cnt_d;
   logic             req_q, req_d;
   logic             sp_q, sp_d;
   logic             err_q, err_d;
   logic             win_q, win_d;
   logic             lose_q, lose_d;

   logic             legal, natural, craps, seven;
   logic             accept;
   logic             limit_hit;

   craps_sum_classify #(.SUM_W(SUM_W)) u_classify (
      .roll_sum (roll_sum),
      .legal    (legal),
      .natural  (natural),
      .craps    (craps),
      .seven    (seven)
   );

   // req_q mirrors state_q being COMEOUT/POINT, so it gates acceptance.
   assign accept    = req_q & roll_valid & legal;
   // With an unlimited phase (0) the counter still runs but is never consulted.
   assign limit_hit = (MAX_POINT_ROLLS > 0) &&
                      (int'(pr_cnt_q) == MAX_POINT_ROLLS - 1);

   always_comb begin
      state_d  = state_q;
      point_d  = point_q;
      cnt_d    = cnt_q;
      pr_cnt_d = pr_cnt_q;
      sp_d     = 1'b0;
      err_d    = req_q & roll_valid & ~legal;

      case (state_q)
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (enter) begin
               state_d = ST_COMEOUT;
               point_d = '0;
               cnt_d   = '0;
            end
         end
         ST_COMEOUT: begin
            if (accept) begin
               if (natural) begin
                  state_d = ST_WIN;
               end else if (craps) begin
                  state_d = ST_LOSE;
               end else begin
                  state_d  = ST_POINT;
                  point_d  = roll_sum;
                  sp_d     = 1'b1;
                  pr_cnt_d = '0;
               end
            end
         end
         ST_POINT: begin
            if (accept) begin
               pr_cnt_d = pr_cnt_q + 1'b1;
               if (roll_sum == point_q) begin
                  state_d = ST_WIN;
               end else if (seven || limit_hit) begin
                  state_d = ST_LOSE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Acceptance only happens in COMEOUT/POINT, never alongside the clear.
      if (accept && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end

      win_d  = (state_d == ST_WIN);
      lose_d = (state_d == ST_LOSE);
      req_d  = state_busy(state_d);
   end

   always_ff @(posedge clk_main) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         point_q  <= '0;
         cnt_q    <= '0;
         pr_cnt_q <= '0;
         req_q    <= 1'b0;
         sp_q     <= 1'b0;
         err_q    <= 1'b0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         point_q  <= point_d;
         cnt_q    <= cnt_d;
         pr_cnt_q <= pr_cnt_d;
         req_q    <= req_d;
         sp_q     <= sp_d;
         err_q    <= err_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
      end
   end

   assign roll_req   = req_q;
   assign busy       = req_q;   // busy and roll_req are the same condition
   assign sp         = sp_q;
   assign point_val  = point_q;
   assign win        = win_q;
   assign lose       = lose_q;
   assign sum_err    = err_q;
   assign roll_count = cnt_q;

`ifdef CRAPS_STATS_EN
   logic [CNT_W-1:0] wins_q, wins_d;
   logic [CNT_W-1:0] losses_q, losses_d;

   // Count only the transition into WIN/LOSE, not the cycles spent there.
   always_comb begin
      wins_d   = wins_q;
      losses_d = losses_q;
      if ((state_d == ST_WIN) && (state_q != ST_WIN) && (wins_q != '1)) begin
         wins_d = wins_q + 1'b1;
      end
      if ((state_d == ST_LOSE) && (state_q != ST_LOSE) && (losses_q != '1)) begin
         losses_d = losses_q + 1'b1;
      end
   end

   always_ff @(posedge clk_main) begin
      if (reset) begin
         wins_q   <= '0;
         losses_q <= '0;
      end else begin
         wins_q   <= wins_d;
         losses_q <= losses_d;
      end
   end

   assign wins   = wins_q;
   assign losses = losses_q;
`else
   assign wins   = '0;
   assign losses = '0;
`endif

endmodule

// File: tb/tb_craps_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_craps_round_ctrl
// Drives two controllers from the same stimulus: one with an unlimited point
// phase and 8-bit counters, one with a 2-roll point limit and 2-bit counters.
// A rule-level game model per instance predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_craps_round_ctrl;

   localparam int RST = -3;   // stimulus code: assert reset
   localparam int ENT = -1;   // stimulus code: enter pulse
   localparam int NOP = -2;   // stimulus code: idle cycle
   // codes >= 0: roll_valid with that sum

`ifdef CRAPS_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk_main = 1'b0;
   logic       reset = 1'b1;
   logic       enter = 1'b0;
   logic       roll_valid = 1'b0;
   logic [3:0] roll_sum = 4'd0;

   always #5 clk_main = ~clk_main;

   logic       rr0, sp0, win0, lose0, busy0, err0;
   logic [3:0] pv0;
   logic [7:0] rc0, w0, l0;
   logic       rr1, sp1, win1, lose1, busy1, err1;
   logic [3:0] pv1;
   logic [1:0] rc1, w1, l1;

   craps_round_ctrl #(.SUM_W(4), .CNT_W(8), .MAX_POINT_ROLLS(0)) dut_free (
      .clk_main(clk_main), .reset(reset), .enter(enter), .roll_valid(roll_valid),
      .roll_sum(roll_sum), .roll_req(rr0), .sp(sp0), .point_val(pv0), .win(win0),
      .lose(lose0), .busy(busy0), .sum_err(err0), .roll_count(rc0), .wins(w0),
      .losses(l0));

   craps_round_ctrl #(.SUM_W(4), .CNT_W(2), .MAX_POINT_ROLLS(2)) dut_lim (
      .clk_main(clk_main), .reset(reset), .enter(enter), .roll_valid(roll_valid),
      .roll_sum(roll_sum), .roll_req(rr1), .sp(sp1), .point_val(pv1), .win(win1),
      .lose(lose1), .busy(busy1), .sum_err(err1), .roll_count(rc1), .wins(w1),
      .losses(l1));

   // Packed view: {roll_req,busy,sp,sum_err,win,lose,point[4],count[8],wins[8],losses[8]}
   logic [33:0] act [2];
   assign act[0] = {rr0, busy0, sp0, err0, win0, lose0, pv0, rc0, w0, l0};
   assign act[1] = {rr1, busy1, sp1, err1, win1, lose1, pv1,
                    6'd0, rc1, 6'd0, w1, 6'd0, l1};

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model (game rules) ----------------
   int lim  [2] = '{0, 2};
   int cmax [2] = '{255, 3};
   bit m_active [2];      // a round is being played (rolls wanted)
   bit m_win [2], m_lose [2], m_sp [2], m_err [2];
   int m_point [2];       // 0 = no point yet
   int m_count [2], m_wins [2], m_losses [2], m_prolls [2];

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic finish_round(input int i, input bit won);
      m_active[i] = 1'b0;
      if (won) begin
         m_win[i] = 1'b1;
         if (STATS) m_wins[i] = sat(m_wins[i] + 1, cmax[i]);
      end else begin
         m_lose[i] = 1'b1;
         if (STATS) m_losses[i] = sat(m_losses[i] + 1, cmax[i]);
      end
   endtask

   task automatic model_step(input int i, input bit r, input bit e, input bit v, input int s);
      m_sp[i]  = 1'b0;
      m_err[i] = 1'b0;
      if (r) begin
         m_active[i] = 0; m_win[i] = 0; m_lose[i] = 0; m_point[i] = 0;
         m_count[i] = 0; m_wins[i] = 0; m_losses[i] = 0; m_prolls[i] = 0;
      end else if (!m_active[i]) begin
         if (e) begin
            m_active[i] = 1; m_win[i] = 0; m_lose[i] = 0;
            m_point[i] = 0; m_count[i] = 0;
         end
      end else if (v) begin
         if (s < 2 || s > 12) begin
            m_err[i] = 1'b1;
         end else begin
            m_count[i] = sat(m_count[i] + 1, cmax[i]);
            if (m_point[i] == 0) begin
               if (s == 7 || s == 11)                finish_round(i, 1'b1);
               else if (s == 2 || s == 3 || s == 12) finish_round(i, 1'b0);
               else begin
                  m_point[i] = s; m_sp[i] = 1'b1; m_prolls[i] = 0;
               end
            end else begin
               m_prolls[i]++;
               if (s == m_point[i])                           finish_round(i, 1'b1);
               else if (s == 7)                               finish_round(i, 1'b0);
               else if (lim[i] > 0 && m_prolls[i] == lim[i])  finish_round(i, 1'b0);
            end
         end
      end
   endtask

   function automatic logic [33:0] exp_vec(input int i);
      return {m_active[i], m_active[i], m_sp[i], m_err[i], m_win[i], m_lose[i],
              4'(m_point[i]), 8'(m_count[i]), 8'(m_wins[i]), 8'(m_losses[i])};
   endfunction

   // One clock of stimulus; model advances at the same edge, outputs sampled #1 later.
   task automatic step(input bit r, input bit e, input bit v, input int s);
      reset = r; enter = e; roll_valid = v; roll_sum = 4'(s);
      @(posedge clk_main);
      for (int i = 0; i < 2; i++) model_step(i, r, e, v, s);
      #1;
   endtask

   task automatic apply(input int c);
      step(c == RST, c == ENT, c >= 0, (c >= 0) ? c : 0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1, 7);
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (act[i] !== 34'd0) begin
            n_fail++;
            $display("FAIL reset dut%0d: got %h expected 0", i, act[i]);
         end
      end
   endtask

   task automatic test_comeout();
      int seq[$] = '{ENT, 7, NOP, ENT, 3, ENT, NOP, 11, ENT, 12, 5};
      foreach (seq[k]) begin
         apply(seq[k]);
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (act[i] !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL comeout step %0d dut%0d: got %h expected %h", k, i, act[i], exp_vec(i));
            end
            if (k == 1) begin
               n_tests++;
               if ({win0, rc0, busy0, rr0} !== {1'b1, 8'd1, 1'b0, 1'b0}) begin
                  n_fail++;
                  $display("FAIL comeout_win_direct: got win=%b cnt=%0d busy=%b req=%b expected 1/1/0/0",
                           win0, rc0, busy0, rr0);
               end
            end
            if (k == 5) begin
               n_tests++;
               if ({win0, lose0, rc0, rr0} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
                  n_fail++;
                  $display("FAIL restart_clear: got win=%b lose=%b cnt=%0d req=%b expected 0/0/0/1",
                           win0, lose0, rc0, rr0);
               end
            end
         end
      end
   endtask

   task automatic test_point();
      int seq[$] = '{ENT, 6, 4, 9, 6, NOP, ENT, 8, 7, NOP};
      foreach (seq[k]) begin
         apply(seq[k]);
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (act[i] !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL point step %0d dut%0d: got %h expected %h", k, i, act[i], exp_vec(i));
            end
         end
         if (k == 1) begin
            n_tests++;
            if ({sp0, pv0} !== {1'b1, 4'd6}) begin
               n_fail++;
               $display("FAIL point_load: got sp=%b point=%0d expected 1/6", sp0, pv0);
            end
         end
         if (k == 4) begin
            n_tests++;
            if ({win0, rc0, lose1} !== {1'b1, 8'd4, 1'b1}) begin
               n_fail++;
               $display("FAIL point_win: got win0=%b cnt0=%0d lose1=%b expected 1/4/1", win0, rc0, lose1);
            end
         end
         if (k == 8) begin
            n_tests++;
            if ({lose0, pv0, win0} !== {1'b1, 4'd8, 1'b0}) begin
               n_fail++;
               $display("FAIL seven_out: got lose=%b point=%0d win=%b expected 1/8/0", lose0, pv0, win0);
            end
         end
      end
   endtask

   task automatic test_roll_limit();
      // valid while idle, 13 while requesting, enter mid-round, then limit loss
      int seq[$] = '{NOP, 9, ENT, 13, 5, ENT, 0, 4, 15, 10, NOP};
      foreach (seq[k]) begin
         apply(seq[k]);
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (act[i] !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL limit step %0d dut%0d: got %h expected %h", k, i, act[i], exp_vec(i));
            end
         end
         if (k == 1) begin
            n_tests++;
            if ({err0, err1} !== 2'b00) begin
               n_fail++;
               $display("FAIL idle_valid_err: got %b%b expected 00", err0, err1);
            end
         end
         if (k == 3) begin
            n_tests++;
            if ({err1, rr1, rc1, sp1} !== {1'b1, 1'b1, 2'd0, 1'b0}) begin
               n_fail++;
               $display("FAIL sum_err13: got err=%b req=%b cnt=%0d sp=%b expected 1/1/0/0", err1, rr1, rc1, sp1);
            end
         end
         if (k == 9) begin
            n_tests++;
            if ({lose1, win1, busy1, lose0, busy0} !== 5'b10001) begin
               n_fail++;
               $display("FAIL limit_loss: got lose1=%b win1=%b busy1=%b lose0=%b busy0=%b expected 1/0/0/0/1",
                        lose1, win1, busy1, lose0, busy0);
            end
         end
      end
   endtask

   task automatic test_stats_and_mid_reset();
      int seq[$] = '{RST, ENT, 7, ENT, 11, ENT, 7, ENT, 7, ENT, 6, 5, RST};
      foreach (seq[k]) begin
         apply(seq[k]);
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (act[i] !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL stats step %0d dut%0d: got %h expected %h", k, i, act[i], exp_vec(i));
            end
         end
         if (k == 8) begin
            n_tests++;
            if ({w1, w0} !== (STATS ? {2'd3, 8'd4} : 10'd0)) begin
               n_fail++;
               $display("FAIL wins_sat: got w1=%0d w0=%0d expected %0d/%0d", w1, w0,
                        STATS ? 3 : 0, STATS ? 4 : 0);
            end
         end
         if (k == 12) begin
            n_tests++;
            if ({act[0], act[1]} !== 68'd0) begin
               n_fail++;
               $display("FAIL mid_point_reset: got %h %h expected 0", act[0], act[1]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      // enter lands on the very cycle after each result
      for (int r = 0; r < 12; r++) begin
         apply(ENT);
         apply((r % 3 == 0) ? 7 : (r % 3 == 1) ? 2 : 4);
         if (r % 3 == 2) apply(7);
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (act[i] !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL back_to_back round %0d dut%0d: got %h expected %h", r, i, act[i], exp_vec(i));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         bit r, e, v;
         int s;
         r = ($urandom % 250) == 0;
         e = ($urandom % 5) == 0;
         v = ($urandom % 3) != 0;
         s = (($urandom % 8) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(2, 12));
         step(r, e, v, s);
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (act[i] !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL random cycle %0d dut%0d: got %h expected %h", c, i, act[i], exp_vec(i));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_comeout();
      test_point();
      test_roll_limit();
      test_stats_and_mid_reset();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
